// File: rtl/drive_cmd_pkg.sv
//------------------------------------------------------------------------------
// Module  : drive_cmd_pkg
// Purpose : Drive command width, type and codes shared by the drive path.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package drive_cmd_pkg;

    localparam int CMD_W = 3;

    typedef logic [CMD_W-1:0] drive_cmd_t;

    localparam drive_cmd_t STOP_CMD    = 3'd0;
    localparam drive_cmd_t FWD_CMD     = 3'd1;
    localparam drive_cmd_t REV_CMD     = 3'd2;
    localparam drive_cmd_t LEFT_CMD    = 3'd3;
    localparam drive_cmd_t RIGHT_CMD   = 3'd4;
    localparam drive_cmd_t SPIN_L_CMD  = 3'd5;
    localparam drive_cmd_t SPIN_R_CMD  = 3'd6;
    localparam drive_cmd_t BRAKE_CMD   = 3'd7;

endpackage

`default_nettype wire

// File: rtl/cmd_stability_counter.sv
//------------------------------------------------------------------------------
// Module  : cmd_stability_counter
// Purpose : Tracks the candidate command and its run of matching samples,
//           pulsing o_commit when it qualifies or when STOP bypasses the wait.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cmd_stability_counter
    import drive_cmd_pkg::*;
#(
    parameter int               CMD_W         = drive_cmd_pkg::CMD_W,
    parameter logic [CMD_W-1:0] STOP_CMD      = drive_cmd_pkg::STOP_CMD,
    parameter int               STABLE_CYCLES = 500_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_sample,
    input  logic [CMD_W-1:0] i_sample_cmd,
    input  logic [CMD_W-1:0] i_committed,
    input  logic             i_force_stop,
    output logic             o_commit,
    output logic [CMD_W-1:0] o_commit_cmd
);

    localparam int                 c_CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [CMD_W-1:0]   r_candidate;
    logic [c_CNT_W-1:0] r_stab_cnt;
    logic [CMD_W-1:0]   w_cand_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_bypass;
    logic               w_qualified;

    always_comb begin
        w_cand_nxt = r_candidate;
        w_cnt_nxt  = r_stab_cnt;
        if (i_sample) begin
            if (i_sample_cmd != r_candidate) begin
                w_cand_nxt = i_sample_cmd;
                w_cnt_nxt  = c_CNT_ONE;
            end else if (r_stab_cnt != c_CNT_MAX) begin
                w_cnt_nxt = r_stab_cnt + c_CNT_ONE;
            end
        end
    end

    // STOP never waits for qualification once something else is committed.
    assign w_bypass    = i_sample && (i_sample_cmd == STOP_CMD) && (i_committed != STOP_CMD);
    assign w_qualified = i_sample && (w_cnt_nxt == c_CNT_MAX) && (w_cand_nxt != i_committed);

    assign o_commit     = w_bypass || w_qualified;
    assign o_commit_cmd = w_cand_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_candidate <= STOP_CMD;
            r_stab_cnt  <= '0;
        end else if (i_force_stop) begin
            r_candidate <= STOP_CMD;
            r_stab_cnt  <= '0;
        end else begin
            r_candidate <= w_cand_nxt;
            r_stab_cnt  <= w_cnt_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/drive_cmd_qualifier.sv
//------------------------------------------------------------------------------
// Module  : drive_cmd_qualifier
// Purpose : Debounces drive commands, offers them on valid/ready, re-issues
//           the held command as a keep-alive and forces STOP on silence.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module drive_cmd_qualifier
    import drive_cmd_pkg::*;
#(
    parameter int               CMD_W          = drive_cmd_pkg::CMD_W,
    parameter logic [CMD_W-1:0] STOP_CMD       = drive_cmd_pkg::STOP_CMD,
    parameter int               STABLE_CYCLES  = 500_000,
    parameter int               REPEAT_CYCLES  = 25_000_000,
    parameter int               TIMEOUT_CYCLES = 50_000_000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [CMD_W-1:0] cmd_in,
    input  logic             cmd_valid,
    output logic [CMD_W-1:0] cmd_out,
    output logic             cmd_out_valid,
    input  logic             cmd_out_ready,
    output logic [CMD_W-1:0] committed_cmd,
    output logic             timeout
);

    localparam int                 c_REP_W    = $clog2(REPEAT_CYCLES + 1);
    localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT_CYCLES - 1);
    localparam logic [c_REP_W-1:0] c_REP_ONE  = c_REP_W'(1);
    localparam int                 c_WD_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_WD_W-1:0]  c_WD_LAST  = c_WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_WD_W-1:0]  c_WD_MAX   = c_WD_W'(TIMEOUT_CYCLES);
    localparam logic [c_WD_W-1:0]  c_WD_ONE   = c_WD_W'(1);

    localparam logic [0:0] c_S_IDLE  = 1'b0;
    localparam logic [0:0] c_S_OFFER = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [CMD_W-1:0]   r_cmd_out;
    logic [CMD_W-1:0]   r_committed;
    logic [c_REP_W-1:0] r_rep_cnt;
    logic [c_WD_W-1:0]  r_wd_cnt;
    logic               r_timeout;
    logic               r_boot;

    logic               w_commit;
    logic [CMD_W-1:0]   w_commit_cmd;
    logic               w_xfer;
    logic               w_expire;
    logic               w_repeat;
    logic               w_load;
    logic [CMD_W-1:0]   w_load_cmd;

    cmd_stability_counter #(
        .CMD_W         (CMD_W),
        .STOP_CMD      (STOP_CMD),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) u_stab (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_sample     (cmd_valid),
        .i_sample_cmd (cmd_in),
        .i_committed  (r_committed),
        .i_force_stop (w_expire),
        .o_commit     (w_commit),
        .o_commit_cmd (w_commit_cmd)
    );

    assign w_xfer   = (r_state == c_S_OFFER) && cmd_out_ready;
    assign w_expire = !cmd_valid && (r_wd_cnt == c_WD_LAST);
    assign w_repeat = (r_state == c_S_IDLE) && (r_rep_cnt == c_REP_LAST);

    // r_boot forces the one-shot STOP offer right after reset release.
    assign w_load     = w_commit || w_expire || w_repeat || r_boot;
    assign w_load_cmd = w_commit ? w_commit_cmd : (w_expire ? STOP_CMD : r_committed);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (w_load) w_state_nxt = c_S_OFFER;
            c_S_OFFER: if (w_xfer && !w_load) w_state_nxt = c_S_IDLE;
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= c_S_IDLE;
            r_cmd_out   <= STOP_CMD;
            r_committed <= STOP_CMD;
            r_rep_cnt   <= '0;
            r_wd_cnt    <= '0;
            r_timeout   <= 1'b0;
            r_boot      <= 1'b1;
        end else begin
            r_boot  <= 1'b0;
            r_state <= w_state_nxt;
            if (w_load) begin
                r_cmd_out <= w_load_cmd;
            end

            if (w_commit) begin
                r_committed <= w_commit_cmd;
            end else if (w_expire) begin
                r_committed <= STOP_CMD;
            end

            if (w_load || w_xfer) begin
                r_rep_cnt <= '0;
            end else if ((r_state == c_S_IDLE) && (r_rep_cnt != c_REP_LAST)) begin
                r_rep_cnt <= r_rep_cnt + c_REP_ONE;
            end

            if (cmd_valid) begin
                r_wd_cnt <= '0;
            end else if (r_wd_cnt != c_WD_MAX) begin
                r_wd_cnt <= r_wd_cnt + c_WD_ONE;
            end

            if (cmd_valid) begin
                r_timeout <= 1'b0;
            end else if (w_expire) begin
                r_timeout <= 1'b1;
            end
        end
    end

    assign cmd_out       = r_cmd_out;
    assign cmd_out_valid = (r_state == c_S_OFFER);
    assign committed_cmd = r_committed;
    assign timeout       = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_drive_cmd_qualifier.sv
//------------------------------------------------------------------------------
// Module  : tb_drive_cmd_qualifier
// Purpose : Self-checking bench for drive_cmd_qualifier with a cycle model.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_drive_cmd_qualifier;
    import drive_cmd_pkg::*;

    localparam int STABLE  = 4;
    localparam int REPEAT  = 20;
    localparam int TMO     = 50;
    localparam int STOP    = int'(STOP_CMD);

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    drive_cmd_t cmd_in = '0;
    logic       cmd_valid = 1'b0;
    drive_cmd_t cmd_out;
    logic       cmd_out_valid;
    logic       cmd_out_ready = 1'b1;
    drive_cmd_t committed_cmd;
    logic       timeout;

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;
    int xlog_v[$];
    int xlog_t[$];
    logic       prev_valid = 1'b0;
    drive_cmd_t prev_out = '0;

    // model state: debouncer run, committed value, pending offer, idle and silent cycle counts
    int m_cand, m_run, m_comm, m_pend, m_out, m_idle, m_silent, m_tmo, m_boot;

    drive_cmd_qualifier #(
        .CMD_W          (3),
        .STOP_CMD       (3'd0),
        .STABLE_CYCLES  (STABLE),
        .REPEAT_CYCLES  (REPEAT),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_in        (cmd_in),
        .cmd_valid     (cmd_valid),
        .cmd_out       (cmd_out),
        .cmd_out_valid (cmd_out_valid),
        .cmd_out_ready (cmd_out_ready),
        .committed_cmd (committed_cmd),
        .timeout       (timeout)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_cand = STOP; m_run = 0; m_comm = STOP; m_pend = 0; m_out = STOP;
        m_idle = 0; m_silent = 0; m_tmo = 0; m_boot = 1;
    endtask

    task automatic m_step(input int v, input int c, input int rdy);
        bit commit, expire, rep, load, xfer;
        int commit_v, lval;
        commit = 0; expire = 0; commit_v = 0;
        if (v != 0) begin
            if (c == STOP && m_comm != STOP) begin
                commit = 1; commit_v = STOP;
            end
            if (c != m_cand) begin
                m_cand = c; m_run = 1;
            end else if (m_run < STABLE) begin
                m_run++;
            end
            if (m_run == STABLE && m_cand != m_comm) begin
                commit = 1; commit_v = m_cand;
            end
            m_silent = 0;
            m_tmo = 0;
        end else begin
            m_silent++;
            expire = (m_silent == TMO);
        end
        if (m_pend == 0) m_idle++;
        rep  = (m_pend == 0) && (m_idle == REPEAT);
        load = commit || expire || rep || (m_boot != 0);
        lval = commit ? commit_v : (expire ? STOP : m_comm);
        xfer = (m_pend != 0) && (rdy != 0);
        if (commit) begin
            m_comm = commit_v;
        end else if (expire) begin
            m_comm = STOP; m_cand = STOP; m_run = 0; m_tmo = 1;
        end
        if (load) begin
            m_pend = 1; m_out = lval; m_idle = 0;
        end else if (xfer) begin
            m_pend = 0; m_idle = 0;
        end
        m_boot = 0;
    endtask

    always @(posedge clk) begin
        if (reset_n) begin
            if (prev_valid && cmd_out_ready) begin
                xlog_v.push_back(int'(prev_out));
                xlog_t.push_back(cyc_no);
            end
            m_step(int'(cmd_valid), int'(cmd_in), int'(cmd_out_ready));
        end else begin
            m_reset();
        end
        cyc_no++;
        #1;
        chk("model_valid", int'(cmd_out_valid), m_pend);
        if (m_pend != 0) chk("model_cmd_out", int'(cmd_out), m_out);
        chk("model_committed", int'(committed_cmd), m_comm);
        chk("model_timeout", int'(timeout), m_tmo);
        prev_valid = cmd_out_valid;
        prev_out   = cmd_out;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_in(input int c, input bit v);
        cmd_in    = c[2:0];
        cmd_valid = v;
    endtask

    initial begin
        #100000;
        $display("FAIL sim_guard: got timeout expected completion");
        $fatal(1, "guard expired");
    end

    initial begin
        int vin[8];
        int vv[8];
        vin = '{3, 3, 3, 5, 3, 3, 3, 3};
        vv  = '{1, 1, 0, 1, 1, 1, 0, 1};

        // reset and the post-reset STOP offer
        step(3);
        chk("rst_valid", int'(cmd_out_valid), 0);
        chk("rst_cmd_out", int'(cmd_out), 0);
        chk("rst_committed", int'(committed_cmd), 0);
        chk("rst_timeout", int'(timeout), 0);
        reset_n = 1'b1;
        set_in(0, 1);
        step(1);
        chk("boot_valid", int'(cmd_out_valid), 1);
        chk("boot_cmd", int'(cmd_out), 0);
        step(1);
        chk("boot_valid_drop", int'(cmd_out_valid), 0);
        step(3);

        // qualification of a steady command
        set_in(3, 1);
        step(3);
        chk("qual_not_yet", int'(committed_cmd), 0);
        step(1);
        chk("qual_valid", int'(cmd_out_valid), 1);
        chk("qual_cmd", int'(cmd_out), 3);
        chk("qual_committed", int'(committed_cmd), 3);
        step(2);

        // STOP bypass
        set_in(0, 1);
        step(1);
        chk("stop_valid", int'(cmd_out_valid), 1);
        chk("stop_cmd", int'(cmd_out), 0);
        chk("stop_committed", int'(committed_cmd), 0);

        // interrupted run restarts; gaps neither advance nor clear
        foreach (vin[i]) begin
            set_in(vin[i], vv[i][0]);
            step(1);
        end
        chk("restart_no_commit", int'(committed_cmd), 0);
        set_in(3, 1);
        step(1);
        chk("restart_commit", int'(committed_cmd), 3);
        chk("restart_cmd", int'(cmd_out), 3);

        // stalled consumer: latest wins
        cmd_out_ready = 1'b0;
        xlog_v.delete(); xlog_t.delete();
        set_in(2, 1);
        step(4);
        chk("stall_cmd2", int'(cmd_out), 2);
        set_in(4, 1);
        step(4);
        chk("stall_cmd4", int'(cmd_out), 4);
        chk("stall_valid", int'(cmd_out_valid), 1);
        step(2);
        cmd_out_ready = 1'b1;
        step(3);
        chk("stall_xfer_count", xlog_v.size(), 1);
        if (xlog_v.size() > 0) chk("stall_xfer_val", xlog_v[0], 4);

        // keep-alive period
        xlog_v.delete(); xlog_t.delete();
        step(70);
        chk("ka_count_ge3", int'(xlog_v.size() >= 3), 1);
        for (int i = 0; i < xlog_v.size(); i++) begin
            chk("ka_val", xlog_v[i], 4);
            if (i > 0) chk("ka_period", xlog_t[i] - xlog_t[i-1], REPEAT + 1);
        end

        // commit landing on the repeat cycle
        xlog_v.delete(); xlog_t.delete();
        for (int i = 0; i < 40 && xlog_v.size() == 0; i++) step(1);
        chk("ka_wait_xfer", int'(xlog_v.size() > 0), 1);
        step(16);
        set_in(6, 1);
        step(3);
        chk("collide_idle", int'(cmd_out_valid), 0);
        step(1);
        chk("collide_valid", int'(cmd_out_valid), 1);
        chk("collide_cmd", int'(cmd_out), 6);
        step(22);
        chk("collide_xfers", xlog_v.size(), 3);
        if (xlog_v.size() >= 3) begin
            chk("collide_v1", xlog_v[1], 6);
            chk("collide_v2", xlog_v[2], 6);
            chk("collide_gap", xlog_t[2] - xlog_t[1], REPEAT + 1);
        end

        // watchdog expiry
        set_in(6, 0);
        step(TMO - 1);
        chk("wd_before_tmo", int'(timeout), 0);
        chk("wd_before_comm", int'(committed_cmd), 6);
        step(1);
        chk("wd_tmo", int'(timeout), 1);
        chk("wd_valid", int'(cmd_out_valid), 1);
        chk("wd_cmd", int'(cmd_out), 0);
        chk("wd_comm", int'(committed_cmd), 0);
        set_in(0, 1);
        step(1);
        chk("wd_clear", int'(timeout), 0);

        // sample on the expiry cycle wins
        set_in(5, 1);
        step(4);
        chk("wd2_comm", int'(committed_cmd), 5);
        set_in(5, 0);
        step(TMO - 1);
        set_in(5, 1);
        step(1);
        chk("wd2_no_tmo", int'(timeout), 0);
        chk("wd2_comm_kept", int'(committed_cmd), 5);
        step(3);
        chk("wd2_comm_later", int'(committed_cmd), 5);

        // reset while an offer is pending
        cmd_out_ready = 1'b0;
        set_in(1, 1);
        step(4);
        chk("mid_valid", int'(cmd_out_valid), 1);
        chk("mid_cmd", int'(cmd_out), 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(cmd_out_valid), 0);
        step(2);
        chk("mid_rst_comm", int'(committed_cmd), 0);
        reset_n = 1'b1;
        step(1);
        chk("mid_boot_valid", int'(cmd_out_valid), 1);
        chk("mid_boot_cmd", int'(cmd_out), 0);
        cmd_out_ready = 1'b1;
        step(1);
        chk("mid_boot_drop", int'(cmd_out_valid), 0);
        step(2);
        chk("mid_requal_valid", int'(cmd_out_valid), 1);
        chk("mid_requal_cmd", int'(cmd_out), 1);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/drive_cmd_qualifier.md
Name: drive_cmd_qualifier

Overview:
- Sits between drive_logic (upstream) and command_translator (downstream) on clk_50.
- Debounces the raw drive command: a new command is forwarded only after it has been stable for a qualification window. STOP bypasses the window.
- Offers each forwarded command on a valid/ready handshake.
- Re-issues the held command periodically as a keep-alive, and forces STOP if drive_logic stops producing valid commands.

Parameters:
- CMD_W, 3, command width (mirrors drive_cmd_pkg::CMD_W)
- STOP_CMD, 3'd0, command code meaning stop
- STABLE_CYCLES, 500_000, matching samples required to commit (10 ms at 50 MHz); must be ≥1
- REPEAT_CYCLES, 25_000_000, keep-alive re-issue period after the last transfer (0.5 s)
- TIMEOUT_CYCLES, 50_000_000, cycles without cmd_valid before STOP is forced (1 s)

Ports:
- clk  in  1  system clock, clk_50 domain
- reset_n  in  1  reset, asynchronous assert, active-low
- cmd_in  in  CMD_W  raw command from drive_logic
- cmd_valid  in  1  cmd_in qualifier from drive_logic
- cmd_out  out  CMD_W  command offered to command_translator
- cmd_out_valid  out  1  offer valid
- cmd_out_ready  in  1  command_translator accepts
- committed_cmd  out  CMD_W  currently committed command (for LCD/status)
- timeout  out  1  watchdog-forced STOP active

Behaviour:
- Reset (reset_n low, async): candidate=committed=cmd_out=STOP_CMD; all counters 0; timeout=0; cmd_out_valid=0.
- First cycle after reset release: cmd_out_valid=1 with STOP_CMD. The robot is always told STOP after reset.
- Sample definition: a cycle with cmd_valid=1. Cycles with cmd_valid=0 neither advance nor clear the stability count.
- On a sample with cmd_in≠candidate: candidate<=cmd_in, stab_cnt<=1.
- On a sample with cmd_in==candidate: stab_cnt increments, saturating at STABLE_CYCLES.
- Commit occurs when stab_cnt reaches STABLE_CYCLES and candidate≠committed. On commit, committed<=candidate and the offer is loaded.
  - cmd_out/cmd_out_valid update on the clock edge after the STABLE_CYCLES-th matching sample.
- STOP bypass: a sample with cmd_in==STOP_CMD and committed≠STOP commits immediately. Offer is visible the next cycle.
- Re-committing the already-committed value never generates an offer.
- FSM, 2 states:
  - IDLE: cmd_out_valid=0. Load → OFFER.
  - OFFER: cmd_out_valid=1, cmd_out held. Transfer (valid&&ready) → IDLE. If a new load arrives in the same cycle as the transfer, stay in OFFER with the new value.
- Latest-wins: a commit during OFFER with no transfer overwrites cmd_out in place and keeps valid=1. At most one offer is ever pending; intermediate commands are dropped.
- Keep-alive:
  - rep_cnt clears on every transfer and increments in IDLE.
  - At REPEAT_CYCLES-1, load committed → OFFER.
  - Commit and repeat in the same cycle: commit wins and rep_cnt clears.
- Watchdog:
  - wd_cnt clears on every sample and increments otherwise, saturating.
  - At TIMEOUT_CYCLES-1: candidate=committed<=STOP, offer STOP (even if already STOP), timeout<=1.
  - timeout clears on the next sample.
  - Sample and expiry in the same cycle: the sample wins, no expiry.
- committed_cmd mirrors the committed register. cmd_out is stable whenever cmd_out_valid=1, except on a latest-wins overwrite.
- Counters are sized with $clog2 of their parameter. No wrap-around; all counters saturate.
- Reset mid-offer: the offer is abandoned, and the post-reset STOP offer follows.

Decomposition:
- drive_cmd_pkg holds: CMD_W; typedef logic [CMD_W-1:0] drive_cmd_t; STOP_CMD and the remaining command codes (shared with drive_logic, command_translator, lcd_display).
- One sub-module, cmd_stability_counter: owns candidate plus the saturating stab_cnt, and emits a commit pulse plus a value.
- The FSM, keep-alive timer and watchdog stay in the top.

Test Plan:
All scenarios run with STABLE_CYCLES=4, REPEAT_CYCLES=20, TIMEOUT_CYCLES=50.
- Reset release, ready=1 → cmd_out_valid=1, cmd_out=0 for exactly one cycle, then 0. committed_cmd=0, timeout=0.
- cmd_in=3 valid each cycle → cmd_out=3 valid on the cycle after the 4th sample. Sequence 3,3,5,3,3 with valid toggling 1,0,1 → no commit of 5; count restarts as specified.
- committed=3, one sample cmd_in=0 → STOP offered next cycle. committed_cmd=0 with no qualification delay.
- ready=0: commit 2, then commit 4 while stalled; raise ready → exactly one transfer, value 4. No transfer of 2 ever.
- Hold committed 3 stable, ready=1 → a re-offer of 3 every 20 idle cycles after each transfer. A commit landing on the repeat cycle yields the new value once.
- cmd_valid low for 50 cycles → STOP offered at cycle 50, timeout=1. Then cmd_valid=1 → timeout=0 the next cycle. Sample on the expiry cycle → no STOP.
